// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the five-stage pipeline front end.
//   - NOP_INST         : instruction word inserted into IF/ID on a bubble
//   - RESET_PC_DEFAULT : default program counter value after reset
//   - if_id_t          : contents of the IF/ID pipeline register
//   - npc_sel_e        : next-PC source, listed from highest to lowest priority
//   - align_word()     : clears the byte-offset bits of a redirect target
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'd0,
    SEL_STALL  = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_SEQ    = 2'd3
  } npc_sel_e;

  // Instruction fetches are word aligned; any low address bits of a target
  // are dropped rather than trapped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Holds one if_id_t record.
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset, clears every field
//     load_i    in   capture d_i on the next edge
//     bubble_i  in   replace contents with an invalid nop (wins over load_i)
//     d_i       in   record to capture when loading
//     q_o       out  registered record
//   With neither load_i nor bubble_i asserted the contents are held.
// -----------------------------------------------------------------------------
module if_id_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_d;
  if_id_t q_q;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d.pc    = 32'h0;
      q_d.pc4   = 32'h0;
      q_d.inst  = NOP_INST;
      q_d.valid = 1'b0;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage: owns the program counter, presents it to a zero-latency
//   instruction memory and captures the returned word into IF/ID together
//   with its PC and PC+4. No branch delay slot: any redirect squashes the
//   word fetched in the same cycle.
//   Parameters:
//     RESET_PC  PC loaded on reset
//     IMEM_AW   word-index width of the instruction memory (the memory itself
//               decodes imem_addr_o[IMEM_AW+1:2]; this block never range-checks)
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     stall_i                          hold PC and IF/ID
//     ex_br_taken_i, ex_br_target_i    taken branch from EX (highest priority)
//     id_jump_i, id_jump_target_i      jump from ID (ignored while stalled)
//     imem_addr_o                      byte address = pc (combinational)
//     imem_inst_i                      instruction for imem_addr_o, same cycle
//     if_id_pc_o, if_id_pc4_o          PC / PC+4 of the IF/ID instruction
//     if_id_inst_o, if_id_valid_o      IF/ID instruction and valid flag
// -----------------------------------------------------------------------------
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_br_taken_i,
  input  logic [31:0] ex_br_target_i,
  input  logic        id_jump_i,
  input  logic [31:0] id_jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  npc_sel_e    npc_sel;
  logic        if_id_load;
  logic        if_id_bubble;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  // A taken branch outranks the stall: the stalled ID instruction is younger
  // than the branch and is being discarded anyway. The jump sits below the
  // stall because the hazard unit re-presents it once the stall clears.
  always_comb begin
    npc_sel = SEL_SEQ;
    if (ex_br_taken_i) begin
      npc_sel = SEL_BRANCH;
    end else if (stall_i) begin
      npc_sel = SEL_STALL;
    end else if (id_jump_i) begin
      npc_sel = SEL_JUMP;
    end
  end

  // 32-bit add wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    unique case (npc_sel)
      SEL_BRANCH: pc_d = align_word(ex_br_target_i);
      SEL_STALL:  pc_d = pc_q;
      SEL_JUMP:   pc_d = align_word(id_jump_target_i);
      SEL_SEQ:    pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr_o = pc_q;

  // IF/ID follows the same selection: redirect -> bubble, stall -> hold,
  // sequential -> capture the word fetched at pc.
  always_comb begin
    if_id_d.pc    = pc_q;
    if_id_d.pc4   = pc_plus4;
    if_id_d.inst  = imem_inst_i;
    if_id_d.valid = 1'b1;
  end

  assign if_id_load   = (npc_sel == SEL_SEQ);
  assign if_id_bubble = (npc_sel == SEL_BRANCH) || (npc_sel == SEL_JUMP);

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (if_id_load),
    .bubble_i (if_id_bubble),
    .d_i      (if_id_d),
    .q_o      (if_id_q)
  );

  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_inst_o  = if_id_q.inst;
  assign if_id_valid_o = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;

  // second instance for the RESET_PC wrap check
  logic        rst2_n;
  logic        zero1;
  logic [31:0] zero32;
  logic [31:0] w_inst;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_inst_o;
  logic        w_valid;

  logic [31:0] mem [256];

  int total;
  int bad;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .ex_br_taken_i    (br_taken),
    .ex_br_target_i   (br_target),
    .id_jump_i        (jump),
    .id_jump_target_i (jump_target),
    .imem_addr_o      (imem_addr),
    .imem_inst_i      (imem_inst),
    .if_id_pc_o       (ifid_pc),
    .if_id_pc4_o      (ifid_pc4),
    .if_id_inst_o     (ifid_inst),
    .if_id_valid_o    (ifid_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(8)) dut_wrap (
    .clk              (clk),
    .rst_n            (rst2_n),
    .stall_i          (zero1),
    .ex_br_taken_i    (zero1),
    .ex_br_target_i   (zero32),
    .id_jump_i        (zero1),
    .id_jump_target_i (zero32),
    .imem_addr_o      (w_addr),
    .imem_inst_i      (w_inst),
    .if_id_pc_o       (w_pc),
    .if_id_pc4_o      (w_pc4),
    .if_id_inst_o     (w_inst_o),
    .if_id_valid_o    (w_valid)
  );

  // zero-latency memory, word index from byte address bits [9:2]
  assign imem_inst = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (state as the spec describes it) -------
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic [31:0] m_inst;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_inst = 0; m_valid = 1'b0;
  endtask

  // Effect of one clock edge with the currently driven inputs.
  task automatic model_edge();
    if (br_taken || (!stall && jump)) begin
      m_pc    = br_taken ? (br_target & ~32'd3) : (jump_target & ~32'd3);
      m_ipc   = 0; m_ipc4 = 0; m_inst = 0; m_valid = 1'b0;
    end else if (!stall) begin
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_inst  = mem[m_pc[9:2]];
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".addr"},  imem_addr, m_pc);
    cmp({tag, ".pc"},    ifid_pc,   m_ipc);
    cmp({tag, ".pc4"},   ifid_pc4,  m_ipc4);
    cmp({tag, ".inst"},  ifid_inst, m_inst);
    cmp({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs [12];

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h8C00_0000 | i;
    mem[0] = 32'h2009_0001;
    mem[1] = 32'h200a_0002;
    mem[2] = 32'h200b_0003;

    //         stall br  br_tgt        jmp jmp_tgt       addr          pc            pc4           inst          v
    vecs[0]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h04, 32'h00, 32'h04, 32'h2009_0001, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h08, 32'h04, 32'h08, 32'h200a_0002, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,      32'h08, 32'h04, 32'h08, 32'h200a_0002, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h90,     32'h08, 32'h04, 32'h08, 32'h200a_0002, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h0C, 32'h08, 32'h0C, 32'h200b_0003, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h43,     32'h40, 32'h00, 32'h00, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h44, 32'h40, 32'h44, 32'h8C00_0010, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h20,   1'b1, 32'h80,     32'h20, 32'h00, 32'h00, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h24, 32'h20, 32'h24, 32'h8C00_0008, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h23,   1'b0, 32'h0,      32'h20, 32'h00, 32'h00, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,      32'h20, 32'h00, 32'h00, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,      32'h24, 32'h20, 32'h24, 32'h8C00_0008, 1'b1};

    stall = 0; br_taken = 0; br_target = 0; jump = 0; jump_target = 0;
    zero1 = 0; zero32 = 0; w_inst = 32'h1234_5678;
    rst_n = 0; rst2_n = 0;

    // reset state
    #12;
    cmp("rst.addr",  imem_addr, 32'h0);
    cmp("rst.pc",    ifid_pc,   32'h0);
    cmp("rst.pc4",   ifid_pc4,  32'h0);
    cmp("rst.inst",  ifid_inst, 32'h0);
    cmp("rst.valid", {31'h0, ifid_valid}, 32'h0);
    cmp("wrap.rst_addr", w_addr, 32'hFFFF_FFFC);
    rst_n = 1; rst2_n = 1;

    // table run
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].stall; br_taken = vecs[i].br; br_target = vecs[i].br_tgt;
      jump = vecs[i].jmp; jump_target = vecs[i].jmp_tgt;
      @(posedge clk); #1;
      cmp($sformatf("vec%0d.addr", i),  imem_addr, vecs[i].e_addr);
      cmp($sformatf("vec%0d.pc", i),    ifid_pc,   vecs[i].e_pc);
      cmp($sformatf("vec%0d.pc4", i),   ifid_pc4,  vecs[i].e_pc4);
      cmp($sformatf("vec%0d.inst", i),  ifid_inst, vecs[i].e_inst);
      cmp($sformatf("vec%0d.valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
      if (i == 0) begin
        // RESET_PC wrap instance has seen exactly one edge
        cmp("wrap.addr",  w_addr,   32'h0);
        cmp("wrap.pc",    w_pc,     32'hFFFF_FFFC);
        cmp("wrap.pc4",   w_pc4,    32'h0);
        cmp("wrap.inst",  w_inst_o, 32'h1234_5678);
        cmp("wrap.valid", {31'h0, w_valid}, 32'h1);
      end
    end

    // asynchronous reset mid-stall, between edges
    stall = 1; br_taken = 0; jump = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    cmp("areset.addr",  imem_addr, 32'h0);
    cmp("areset.pc",    ifid_pc,   32'h0);
    cmp("areset.pc4",   ifid_pc4,  32'h0);
    cmp("areset.inst",  ifid_inst, 32'h0);
    cmp("areset.valid", {31'h0, ifid_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    stall = 0;
    @(posedge clk); #1;
    cmp("after_rst.addr", imem_addr, 32'h4);
    cmp("after_rst.inst", ifid_inst, 32'h2009_0001);

    // randomized run against the reference model
    model_reset();
    model_edge();  // account for the edge just taken from reset state
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(3) == 0);
      br_taken    = ($urandom_range(7) == 0);
      br_target   = $urandom;
      jump        = ($urandom_range(5) == 0);
      jump_target = $urandom;
      if ($urandom_range(15) == 0) br_target = 32'hFFFF_FFFC;
      model_edge();
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the five-stage pipeline.
- Owns the program counter and drives the word address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register together with PC and PC+4.
- Applies hazard-unit stalls and control-flow redirects: taken branch from EX, jump from ID.
- No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 8, word-index width of instruction memory; the address presented is byte-addressed, bits [IMEM_AW+1:2] index the word.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC and IF/ID contents (load-use hazard)
- ex_br_taken_i  in  1  branch resolved taken in EX
- ex_br_target_i  in  32  branch target byte address
- id_jump_i  in  1  j/jal/jr decoded in ID
- id_jump_target_i  in  32  jump target byte address
- imem_addr_o  out  32  byte address to instruction memory (combinational read)
- imem_inst_i  in  32  instruction word returned for imem_addr_o, same cycle
- if_id_pc_o  out  32  PC of instruction held in IF/ID
- if_id_pc4_o  out  32  PC+4 of that instruction
- if_id_inst_o  out  32  instruction held in IF/ID (32'h0 = nop when bubble)
- if_id_valid_o  out  1  1 = IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall or mid-redirect):
  - pc=RESET_PC.
  - if_id_pc_o, if_id_pc4_o and if_id_inst_o = 0; if_id_valid_o = 0.
- imem_addr_o = pc, combinational.
- Memory read is zero-latency; imem_inst_i is sampled on the same edge that updates pc.
- Next-PC priority, highest first:
  1. ex_br_taken_i=1 -> ex_br_target_i. Overrides stall_i, because the stalled ID instruction is younger than the branch and is discarded.
  2. stall_i=1 -> pc held. id_jump_i is ignored while stalled; the hazard unit re-presents it once the stall clears.
  3. id_jump_i=1 -> id_jump_target_i.
  4. otherwise pc+4.
- Targets have bits [1:0] forced to 0 before loading.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- IF/ID update per edge, same priority:
  - Redirect (case 1 or 3): load bubble. valid=0, inst=32'h0, pc and pc4 fields = 0. The fetched wrong-path word is discarded.
  - Stall (case 2): all IF/ID fields held unchanged.
  - Normal (case 4): pc field=pc, pc4 field=pc+4, inst=imem_inst_i, valid=1.
- Latency: an instruction at address A appears in IF/ID one cycle after pc=A.
- Redirect penalty:
  - jump: 1 bubble;
  - taken branch: 1 bubble in IF/ID (ID/EX flush is the hazard unit's job).
- Simultaneous ex_br_taken_i and id_jump_i: the branch wins; the jump belongs to the wrong path.
- No out-of-range check: addresses beyond the memory alias via the memory's own index decode.
- Outputs are registered; there are no combinational paths from the *_i controls to if_id_* outputs.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INST = 32'h0000_0000;
  - RESET_PC default;
  - if_id_t struct {pc, pc4, inst, valid};
  - redirect-select enum {SEL_BRANCH, SEL_STALL, SEL_JUMP, SEL_SEQ}.
- One sub-module, if_id_reg: holds if_id_t with async active-low reset, and load/hold/bubble control inputs.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then free-run, memory words 0..2 = 32'h20090001, 32'h200a0002, 32'h200b0003:
  - imem_addr_o steps 0, 4, 8;
  - IF/ID shows inst 32'h20090001 / pc 0 / pc4 4 / valid 1, then 32'h200a0002 / pc 4, then 32'h200b0003 / pc 8.
- stall_i=1 for 2 cycles at pc=8: pc stays 8, IF/ID holds 32'h200a0002 / pc 4; on release, the next edge loads 32'h200b0003.
- id_jump_i=1, target 32'h0000_0043 at pc=8: next pc=32'h40; IF/ID valid=0, inst=0 for one cycle, then the word from 0x40 with pc 0x40.
- ex_br_taken_i=1 (target 0x20) together with stall_i=1 and id_jump_i=1 (target 0x80): pc=0x20, IF/ID bubble; stall and jump have no effect.
- pc preloaded via RESET_PC=32'hFFFF_FFFC: after one edge pc=0, if_id_pc4_o=0.
- rst_n pulsed low asynchronously between edges during a stall: pc and all IF/ID outputs go to reset values immediately, without waiting for a clock edge.
